// File: rtl/fir_axilite_cfg_if.sv
// AXI-Lite bundle between the Wishbone bridge and the FIR config front end.
// The bridge side is the master, the register block is the slave.
interface fir_axilite_cfg_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) ();
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );
endinterface

// File: rtl/fir_axilite_cfg.sv
// FIR configuration front end: ap_ctrl, data_length and tap RAM behind AXI-Lite,
// plus the start/done handshake with the compute engine.
module fir_axilite_cfg #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fir_axilite_cfg_if.slave       axi,
    output logic                   tap_EN,
    output logic [3:0]             tap_WE,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   ap_start,
    output logic [pDATA_WIDTH-1:0] data_length,
    input  logic                   eng_start_ack,
    input  logic                   eng_done
);
    localparam int AW = pADDR_WIDTH;
    localparam int DW = pDATA_WIDTH;
    localparam int WA = AW - 2;

    localparam logic [WA-1:0] CTRL_W = WA'(0);
    localparam logic [WA-1:0] LEN_W  = WA'(4);
    localparam logic [WA-1:0] TAP_LO = WA'(8);
    localparam logic [WA-1:0] TAP_HI = WA'(8 + Tape_Num);
    localparam logic [AW-1:0] TAP_BASE = AW'(32);

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_WAIT} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_WAIT} r_state_t;

    function automatic logic in_tap(input logic [WA-1:0] w);
        return (w >= TAP_LO) && (w < TAP_HI);
    endfunction

    function automatic logic [AW-1:0] tap_off(input logic [WA-1:0] w);
        return {w, 2'b00} - TAP_BASE;
    endfunction

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic          ap_done, ap_idle;
    logic [WA-1:0] aw_w, ar_w;
    logic          r_busy_q, r_fresh;
    logic [DW-1:0] rd_live, rd_hold;
    logic          w_hit, wr_ctrl, wr_len, wr_tap, rd_tap, rd_ctrl_hs;

    assign aw_w = axi.awaddr[AW-1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next      = w_state;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        unique case (w_state)
            W_IDLE: if (axi.awvalid && axi.wvalid) w_next = W_ACK;
            W_ACK: begin
                axi.awready = 1'b1;
                axi.wready  = 1'b1;
                w_next      = W_WAIT;
            end
            // the bridge keeps its valids up after completion
            W_WAIT: if (!axi.awvalid && !axi.wvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // a read may only claim the RAM port in a cycle the write will not own
    always_comb begin
        r_next      = r_state;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        unique case (r_state)
            R_IDLE: if (axi.arvalid && w_next != W_ACK) r_next = R_ADDR;
            R_ADDR: begin
                axi.arready = 1'b1;
                r_next      = R_DATA;
            end
            R_DATA: begin
                axi.rvalid = 1'b1;
                axi.rdata  = r_fresh ? rd_live : rd_hold;
                if (axi.rready) r_next = R_WAIT;
            end
            R_WAIT: if (!axi.arvalid) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    assign w_hit      = (w_state == W_ACK);
    assign wr_ctrl    = w_hit && (aw_w == CTRL_W);
    assign wr_len     = w_hit && (aw_w == LEN_W) && ap_idle;
    assign wr_tap     = w_hit && in_tap(aw_w) && ap_idle;
    assign rd_tap     = (r_state == R_ADDR) && ap_idle &&
                        in_tap(axi.araddr[AW-1:2]);
    assign rd_ctrl_hs = (r_state == R_DATA) && axi.rready &&
                        (ar_w == CTRL_W);

    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (wr_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = tap_off(aw_w);
            tap_Di = axi.wdata;
        end else if (rd_tap) begin
            tap_EN = 1'b1;
            tap_A  = tap_off(axi.araddr[AW-1:2]);
        end
    end

    always_comb begin
        unique case (1'b1)
            ar_w == CTRL_W: rd_live = DW'({ap_idle, ap_done, ap_start});
            ar_w == LEN_W:  rd_live = data_length;
            in_tap(ar_w):   rd_live = r_busy_q ? '1 : tap_Do;
            default:        rd_live = '0;
        endcase
    end

    // RAM output is only trusted on the first R_DATA cycle; hold it after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_w     <= '0;
            r_busy_q <= 1'b0;
            r_fresh  <= 1'b0;
            rd_hold  <= '0;
        end else begin
            r_fresh <= (r_state == R_ADDR);
            if (r_state == R_ADDR) begin
                ar_w     <= axi.araddr[AW-1:2];
                r_busy_q <= !ap_idle;
            end
            if (r_fresh) rd_hold <= rd_live;
        end
    end

    // eng_done is applied last so it beats a coincident clearing read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ap_start    <= 1'b0;
            ap_done     <= 1'b0;
            ap_idle     <= 1'b1;
            data_length <= '0;
        end else begin
            if (wr_len) data_length <= axi.wdata;
            if (wr_ctrl && axi.wdata[0] && ap_idle) ap_start <= 1'b1;
            if (eng_start_ack) begin
                ap_start <= 1'b0;
                ap_idle  <= 1'b0;
            end
            if (rd_ctrl_hs) ap_done <= 1'b0;
            if (eng_done) begin
                ap_done <= 1'b1;
                ap_idle <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_axilite_cfg.sv
// Randomized scoreboard bench for fir_axilite_cfg with a register-map model
// and a behavioural tap RAM.
module tb_fir_axilite_cfg;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_axilite_cfg_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) axi ();

    logic          tap_EN;
    logic [3:0]    tap_WE;
    logic [AW-1:0] tap_A;
    logic [DW-1:0] tap_Di;
    logic [DW-1:0] tap_Do = '0;
    logic          ap_start;
    logic [DW-1:0] data_length;
    logic          eng_start_ack = 1'b0;
    logic          eng_done = 1'b0;

    fir_axilite_cfg #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .axi(axi),
        .tap_EN(tap_EN),
        .tap_WE(tap_WE),
        .tap_A(tap_A),
        .tap_Di(tap_Di),
        .tap_Do(tap_Do),
        .ap_start(ap_start),
        .data_length(data_length),
        .eng_start_ack(eng_start_ack),
        .eng_done(eng_done)
    );

    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) mem[tap_A[AW-1:2]] <= tap_Di;
            tap_Do <= mem[tap_A[AW-1:2]];
        end
    end

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] m_tap [NT];
    logic [DW-1:0] m_len;
    bit m_start, m_done, m_idle;

    logic [DW-1:0]    rd_q [$];
    logic [AW+DW-1:0] tw_q [$];

    logic [AW-1:0] unmapped [9] = '{12'h004, 12'h008, 12'h00C, 12'h014,
                                    12'h018, 12'h01C, 12'h04C, 12'h050, 12'hFFC};
    int coef [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        int w;
        w = int'(a[AW-1:2]);
        if (w == 0) return DW'({m_idle, m_done, m_start});
        if (w == 4) return m_len;
        if (w >= 8 && w < 8 + NT) return m_idle ? m_tap[w-8] : '1;
        return '0;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w;
        w = int'(a[AW-1:2]);
        if (w == 0 && d[0] && m_idle) m_start = 1'b1;
        if (w == 4 && m_idle) m_len = d;
        if (w >= 8 && w < 8 + NT && m_idle) begin
            m_tap[w-8] = d;
            tw_q.push_back({AW'((w - 8) * 4), d});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (axi.rvalid && axi.rready) begin
                if (rd_q.size() == 0) fail_now("rd_unexpected");
                else check("rdata", axi.rdata, rd_q.pop_front());
            end
            if (tap_EN && tap_WE != 4'h0) begin
                if (tw_q.size() == 0) fail_now("tap_wr_unexpected");
                else check("tap_wr", {tap_WE, tap_A, tap_Di},
                           {4'hF, tw_q.pop_front()});
            end
            if (tap_EN && tap_WE == 4'h0 && !m_idle) fail_now("tap_rd_busy");
        end
    end

    task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int hold);
        int n, c;
        bit seen;
        n = 0; c = 0; seen = 1'b0;
        model_write(a, d);
        @(posedge clk); #1;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        axi.awaddr = a; axi.wdata = d;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (axi.wready) begin seen = 1'b1; n++; end
        end
        if (!seen) fail_now("wr_timeout");
        else check("wr_latency", c, 2);
        repeat (hold) begin
            @(negedge clk);
            if (axi.wready) n++;
        end
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (axi.wready) n++;
        end
        check("wready_pulses", n, 1);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int rdelay,
                            input bit done_hs);
        int c;
        bit seen;
        c = 0; seen = 1'b0;
        rd_q.push_back(model_read(a));
        @(posedge clk); #1;
        axi.arvalid = 1'b1; axi.araddr = a; axi.rready = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (axi.rvalid) seen = 1'b1;
        end
        if (!seen) begin
            fail_now("rd_timeout");
            void'(rd_q.pop_back());
        end else begin
            check("rd_latency", c - 1, 2);
        end
        repeat (rdelay) begin
            @(negedge clk);
            check("rvalid_held", axi.rvalid, 1);
        end
        @(posedge clk); #1;
        axi.rready = 1'b1;
        if (done_hs) eng_done = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0; axi.arvalid = 1'b0; eng_done = 1'b0;
        if (a[AW-1:2] == '0 && seen) m_done = 1'b0;
        if (done_hs) begin m_done = 1'b1; m_idle = 1'b1; end
    endtask

    task automatic rw_collide(input logic [AW-1:0] wa, input logic [DW-1:0] d,
                              input logic [AW-1:0] ra);
        int w_c, ar_c, rv_c;
        bit fin;
        w_c = 0; ar_c = 0; rv_c = 0; fin = 1'b0;
        model_write(wa, d);
        rd_q.push_back(model_read(ra));
        @(posedge clk); #1;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.awaddr = wa; axi.wdata = d;
        axi.arvalid = 1'b1; axi.araddr = ra; axi.rready = 1'b0;
        for (int c = 1; c <= 15 && !fin; c++) begin
            @(negedge clk);
            if (axi.wready && w_c == 0) w_c = c;
            if (axi.arready && ar_c == 0) ar_c = c;
            if (axi.rvalid && axi.rready) fin = 1'b1;
            if (axi.rvalid && rv_c == 0) rv_c = c;
            @(posedge clk); #1;
            if (w_c != 0) begin axi.awvalid = 1'b0; axi.wvalid = 1'b0; end
            if (rv_c != 0) axi.rready = 1'b1;
        end
        axi.rready = 1'b0; axi.arvalid = 1'b0;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        if (!fin) begin
            fail_now("collide_timeout");
            void'(rd_q.pop_back());
        end
        check("collide_wready_cyc", w_c, 2);
        check("collide_arready_cyc", ar_c, 3);
        check("collide_rvalid_cyc", rv_c, 4);
    endtask

    task automatic eng_ack();
        @(posedge clk); #1;
        eng_start_ack = 1'b1; m_start = 1'b0; m_idle = 1'b0;
        @(posedge clk); #1;
        eng_start_ack = 1'b0;
    endtask

    task automatic eng_fin();
        @(posedge clk); #1;
        eng_done = 1'b1; m_done = 1'b1; m_idle = 1'b1;
        @(posedge clk); #1;
        eng_done = 1'b0;
    endtask

    task automatic model_reset();
        m_len = '0; m_start = 1'b0; m_done = 1'b0; m_idle = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int k, c;
        bit seen;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < NT; i++) m_tap[i] = '0;
        model_reset();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        axi.rready = 1'b0; axi.awaddr = '0; axi.wdata = '0; axi.araddr = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_hs", {axi.awready, axi.wready, axi.arready, axi.rvalid,
                           tap_EN, tap_WE, ap_start}, 0);
        check("reset_rdata", axi.rdata, 0);
        check("reset_tap", {tap_A, tap_Di}, 0);
        check("reset_len", data_length, 0);
        @(negedge clk);
        rst_n = 1'b1;

        axi_read(12'h000, 0, 0);
        axi_write(12'h010, 32'h0000_0258, 3);
        axi_read(12'h010, 1, 0);
        check("data_length", data_length, m_len);

        for (int i = 0; i < NT; i++) begin
            d = coef[i];
            axi_write(AW'(32 + 4 * i), d, 1);
        end
        for (int i = 0; i < NT; i++) axi_read(AW'(32 + 4 * i), i % 2, 0);
        axi_read(12'h04C, 0, 0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            d = $urandom;
            if (k < 5) a = AW'(32 + 4 * $urandom_range(0, NT - 1));
            else if (k < 7) a = 12'h010;
            else if (k == 7) a = 12'h000;
            else a = unmapped[$urandom_range(0, 8)];
            a[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1 && a[AW-1:2] != '0)
                axi_write(a, d, $urandom_range(0, 3));
            else
                axi_read(a, $urandom_range(0, 2), 1'b0);
        end
        check("data_length_rand", data_length, m_len);

        axi_write(12'h000, 32'h1, 1);
        @(negedge clk);
        check("ap_start_set", ap_start, m_start);
        repeat (3) @(negedge clk);
        check("ap_start_hold", ap_start, m_start);
        eng_ack();
        @(negedge clk);
        check("ap_start_ack", ap_start, m_start);
        axi_read(12'h000, 0, 0);

        axi_write(12'h020, 32'h7, 1);
        axi_read(12'h024, 0, 0);
        axi_write(12'h010, 32'h123, 1);
        axi_read(12'h010, 0, 0);
        axi_write(12'h000, 32'h1, 1);
        @(negedge clk);
        check("ap_start_busy", ap_start, m_start);

        eng_fin();
        axi_read(12'h000, 0, 0);
        axi_read(12'h000, 0, 0);

        axi_write(12'h000, 32'h1, 0);
        eng_ack();
        eng_fin();
        axi_write(12'h000, 32'h1, 0);
        eng_ack();
        axi_read(12'h000, 1, 1);
        axi_read(12'h000, 0, 0);
        axi_read(12'h000, 0, 0);

        rw_collide(12'h02C, 32'h0000_ABCD, 12'h02C);
        rw_collide(12'h010, 32'h0000_0077, 12'h010);
        check("data_length_collide", data_length, m_len);

        @(posedge clk); #1;
        axi.arvalid = 1'b1; axi.araddr = 12'h010; axi.rready = 1'b0;
        c = 0; seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (axi.rvalid) seen = 1'b1;
        end
        if (!seen) fail_now("rst_rd_timeout");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_rvalid", {axi.rvalid, axi.arready}, 0);
        check("rst_async_rdata", axi.rdata, 0);
        check("rst_len", data_length, m_len);
        axi.arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        axi_read(12'h010, 0, 0);
        axi_read(12'h000, 0, 0);
        axi_read(12'h02C, 0, 0);

        repeat (3) @(negedge clk);
        check("rd_q_empty", rd_q.size(), 0);
        check("tw_q_empty", tw_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
